// File: rtl/convnet_pkg.sv
// Shared ConvNet USB-path definitions: FX2 endpoint addresses, write-back
// FSM state encoding and the SDRAM word-address helper.
package convnet_pkg;

   localparam logic [1:0] FX2_EP2 = 2'b00;
   localparam logic [1:0] FX2_EP6 = 2'b10;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      REQ      = 3'd1,
      WAIT_ACK = 3'd2,
      WR_LO    = 3'd3,
      WR_HI    = 3'd4,
      COMMIT   = 3'd5,
      DONE     = 3'd6
   } state_e;

   // Word address of entry idx; wraps modulo 2^32.
   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
      return base + {16'd0, idx};
   endfunction

endpackage

// File: rtl/wb_read_master.sv
// Single-read Wishbone handshake: drives the bus during REQ/WAIT_ACK and
// captures the returned word. Only an ack seen in WAIT_ACK is taken, so an
// ack that lingers until cyc drops is latched exactly once.
module wb_read_master
   import convnet_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  state_e      state_i,
   input  logic [31:0] req_addr_i,
   input  logic        stall_i,
   input  logic        ack_i,
   input  logic [31:0] rdata_i,
   output logic        cyc_o,
   output logic        stb_o,
   output logic [3:0]  sel_o,
   output logic [31:0] adr_o,
   output logic        accept_o,
   output logic        ack_o,
   output logic [31:0] word_o
);

   logic [31:0] word_q, word_d;

   assign cyc_o    = (state_i == REQ) || (state_i == WAIT_ACK);
   assign stb_o    = (state_i == REQ);
   assign sel_o    = cyc_o ? 4'b1111 : 4'b0000;
   assign adr_o    = cyc_o ? req_addr_i : 32'd0;
   assign accept_o = stb_o && !stall_i;
   assign ack_o    = (state_i == WAIT_ACK) && ack_i;
   assign word_o   = word_q;

   // Next word value: load read data on the accepted acknowledge.
   always_comb begin
      word_d = word_q;
      if (ack_o) begin
         word_d = rdata_i;
      end else begin
         word_d = word_q;
      end
   end

   // Word register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         word_q <= 32'd0;
      end else begin
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/sdram_to_usb.sv
// Write-back stage: reads WORD_COUNT words from SDRAM over Wishbone and
// streams each as two 16-bit halves (low first) into FX2 EP6, then commits
// the short final packet with PKTEND.
module sdram_to_usb
   import convnet_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'd0,
   parameter int unsigned WORD_COUNT = 120,
   parameter logic [1:0]  FIFO_ADDR  = FX2_EP6
)
(
   input  logic        CLKOUT,
   input  logic        rst,
   input  logic        start,
   input  logic        FLAGB,
   output logic        SLWR,
   output logic        SLRD,
   output logic        SLOE,
   output logic        PKTEND,
   output logic [1:0]  FIFOADR,
   output logic [15:0] FDATA,
   output logic        FDATA_OE,
   output logic        cyc_i,
   output logic        stb_i,
   output logic        we_i,
   output logic [3:0]  sel_i,
   output logic [31:0] addr_i,
   output logic [31:0] data_i,
   input  logic [31:0] data_o,
   input  logic        stall_o,
   input  logic        sdram_ack,
   output logic        busy,
   output logic        done
);

   localparam logic [15:0] LAST_COUNT = 16'(WORD_COUNT);

   state_e      state_q, state_d;
   logic [15:0] index_q, index_d;
   logic        rd_accept_s;
   logic        rd_ack_s;
   logic [31:0] rd_word_s;

   wb_read_master u_rd (
      .clk_i      (CLKOUT),
      .rst_i      (rst),
      .state_i    (state_q),
      .req_addr_i (word_addr(BASE_ADDR, index_q)),
      .stall_i    (stall_o),
      .ack_i      (sdram_ack),
      .rdata_i    (data_o),
      .cyc_o      (cyc_i),
      .stb_o      (stb_i),
      .sel_o      (sel_i),
      .adr_o      (addr_i),
      .accept_o   (rd_accept_s),
      .ack_o      (rd_ack_s),
      .word_o     (rd_word_s)
   );

   assign we_i     = 1'b0;
   assign data_i   = 32'd0;
   assign SLRD     = 1'b1;
   assign SLOE     = 1'b1;
   assign FIFOADR  = FIFO_ADDR;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign FDATA_OE = busy;

   // Next state, index update and FX2 strobes; SLWR/PKTEND follow FLAGB combinationally.
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      SLWR    = 1'b1;
      PKTEND  = 1'b1;
      FDATA   = 16'd0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = REQ;
               index_d = 16'd0;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (rd_accept_s) begin
               state_d = WAIT_ACK;
            end else begin
               state_d = REQ;
            end
         end
         WAIT_ACK: begin
            if (rd_ack_s) begin
               state_d = WR_LO;
            end else begin
               state_d = WAIT_ACK;
            end
         end
         WR_LO: begin
            FDATA = rd_word_s[15:0];
            if (FLAGB) begin
               SLWR    = 1'b0;
               state_d = WR_HI;
            end else begin
               state_d = WR_LO;
            end
         end
         WR_HI: begin
            FDATA = rd_word_s[31:16];
            if (FLAGB) begin
               SLWR    = 1'b0;
               index_d = index_q + 16'd1;
               if (index_d == LAST_COUNT) begin
                  state_d = COMMIT;
               end else begin
                  state_d = REQ;
               end
            end else begin
               state_d = WR_HI;
            end
         end
         COMMIT: begin
            if (FLAGB) begin
               PKTEND  = 1'b0;
               state_d = DONE;
            end else begin
               state_d = COMMIT;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and word-index registers.
   always_ff @(posedge CLKOUT or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         index_q <= 16'd0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
      end
   end

endmodule
